// File: rtl/sprite_rom_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Package     : sprite_rom_pkg
// Description : Shared sizes and the arbiter state type for the sprite memory
//               arbiter and its burst address generator.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
package sprite_rom_pkg;

  localparam int SPR_DEPTH     = 128;
  localparam int SPR_AW        = 7;
  localparam int SPR_DW        = 16;
  localparam int SPR_MAX_BURST = 16;
  // Burst length field must hold 0..SPR_MAX_BURST inclusive.
  localparam int SPR_LW        = $clog2(SPR_MAX_BURST) + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BURST  = 2'd1,
    ST_LAST   = 2'd2,
    ST_SINGLE = 2'd3
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/sprite_rom_burst_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : sprite_rom_burst_gen
// Description : Address and remaining-word counters for one renderer burst.
//               Loads base/length at grant, steps once per issued address,
//               wraps at the top of memory and flags the final address.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
module sprite_rom_burst_gen
  import sprite_rom_pkg::*;
#(
  parameter int DEPTH = SPR_DEPTH,
  parameter int AW    = SPR_AW,
  parameter int LW    = SPR_LW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [AW-1:0] base,
  input  logic [LW-1:0] len,
  input  logic          step,
  output logic [AW-1:0] addr,
  output logic          last
);

  logic [AW-1:0] r_addr;
  logic [LW-1:0] r_remain;
  logic [AW-1:0] w_next_addr;

  // Wrap explicitly at the last word so non-power-of-two depths also work.
  assign w_next_addr = (r_addr == AW'(DEPTH - 1)) ? '0 : r_addr + 1'b1;

  // Counters: load at grant, advance one word per issued address.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr   <= '0;
      r_remain <= '0;
    end else if (load) begin
      r_addr   <= base;
      r_remain <= len;
    end else if (step) begin
      r_addr   <= w_next_addr;
      r_remain <= r_remain - 1'b1;
    end
  end

  assign addr = r_addr;
  assign last = (r_remain == LW'(1));

endmodule
`default_nettype wire

// File: rtl/sprite_rom_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : sprite_rom_arbiter
// Description : Shares one single-port sprite memory (1-cycle read latency)
//               between the display renderer (burst reads, fixed priority)
//               and the HPS bridge (single read/write), with a starvation
//               limit that forces one bridge access after a run of bursts.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
module sprite_rom_arbiter
  import sprite_rom_pkg::*;
#(
  parameter  int DEPTH      = SPR_DEPTH,
  parameter  int DW         = SPR_DW,
  parameter  int STARVE_LIM = 4,
  parameter  int WRITE_EN   = 1,
  localparam int AW         = $clog2(DEPTH),
  localparam int BW         = DW / 8
) (
  input  logic              clk,
  input  logic              reset,
  // renderer burst port
  input  logic              r0_req,
  input  logic [AW-1:0]     r0_base,
  input  logic [SPR_LW-1:0] r0_len,
  output logic              r0_rvalid,
  output logic [DW-1:0]     r0_rdata,
  output logic              r0_done,
  // bridge single-access port
  input  logic              r1_req,
  input  logic [AW-1:0]     r1_addr,
  input  logic              r1_write,
  input  logic [DW-1:0]     r1_wdata,
  input  logic [BW-1:0]     r1_be,
  output logic              r1_ack,
  output logic [DW-1:0]     r1_rdata,
  // memory port
  output logic [AW-1:0]     rom_address,
  output logic              rom_chipselect,
  output logic              rom_write,
  output logic [BW-1:0]     rom_byteenable,
  output logic [DW-1:0]     rom_writedata,
  output logic              rom_clken,
  input  logic [DW-1:0]     rom_readdata
);

  localparam int SW = $clog2(STARVE_LIM + 1);

  arb_state_t    state;
  arb_state_t    state_nxt;

  logic [SW-1:0] r_starve;
  logic          r_rvalid;
  logic          r_ack;
  logic          r_ack_rd;
  logic [AW-1:0] r_r1_addr;
  logic          r_r1_write;
  logic [DW-1:0] r_r1_wdata;
  logic [BW-1:0] r_r1_be;
  logic [DW-1:0] r_r1_rdata;

  logic          w_r1_live;
  logic          w_pick_r1;
  logic          w_r0_grant;
  logic          w_r1_grant;
  logic          w_burst_load;
  logic          w_burst_last;
  logic [AW-1:0] w_burst_addr;
  logic          w_wr_allow;

  generate
    if (WRITE_EN != 0) begin : g_wr_on
      assign w_wr_allow = 1'b1;
    end else begin : g_wr_off
      assign w_wr_allow = 1'b0;
    end
  endgenerate

  // During the ack cycle the bridge still holds its finished request; it must
  // not be re-granted nor counted as waiting.
  assign w_r1_live = r1_req & ~r_ack;
  assign w_pick_r1 = w_r1_live & (~r0_req | (r_starve == SW'(STARVE_LIM)));

  sprite_rom_burst_gen #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .LW    (SPR_LW)
  ) u_burst_gen (
    .clk   (clk),
    .reset (reset),
    .load  (w_burst_load),
    .base  (r0_base),
    .len   (r0_len),
    .step  (state == ST_BURST),
    .addr  (w_burst_addr),
    .last  (w_burst_last)
  );

  // Next-state and grant decode; arbitration happens only in IDLE.
  always_comb begin
    state_nxt    = state;
    w_r0_grant   = 1'b0;
    w_r1_grant   = 1'b0;
    w_burst_load = 1'b0;
    case (state)
      ST_IDLE: begin
        if (w_pick_r1) begin
          w_r1_grant = 1'b1;
          state_nxt  = ST_SINGLE;
        end else if (r0_req) begin
          w_r0_grant = 1'b1;
          if (r0_len == '0) begin
            state_nxt = ST_LAST;
          end else begin
            w_burst_load = 1'b1;
            state_nxt    = ST_BURST;
          end
        end
      end
      ST_BURST:  if (w_burst_last) state_nxt = ST_LAST;
      ST_LAST:   state_nxt = ST_IDLE;
      ST_SINGLE: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Starvation counter: counts renderer grants taken while the bridge waits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= '0;
    end else if (w_r1_grant) begin
      r_starve <= '0;
    end else if (w_r0_grant && w_r1_live) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  // Capture the bridge request at grant so the memory cycle is self-contained.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_r1_addr  <= '0;
      r_r1_write <= 1'b0;
      r_r1_wdata <= '0;
      r_r1_be    <= '0;
    end else if (w_r1_grant) begin
      r_r1_addr  <= r1_addr;
      r_r1_write <= r1_write;
      r_r1_wdata <= r1_wdata;
      r_r1_be    <= r1_be;
    end
  end

  // Read data returns one cycle after each address: delayed valid/ack flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rvalid <= 1'b0;
      r_ack    <= 1'b0;
      r_ack_rd <= 1'b0;
    end else begin
      r_rvalid <= (state == ST_BURST);
      r_ack    <= (state == ST_SINGLE);
      r_ack_rd <= (state == ST_SINGLE) && !r_r1_write;
    end
  end

  // Bridge read data is held between read acks.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_r1_rdata <= '0;
    end else if (r_ack && r_ack_rd) begin
      r_r1_rdata <= rom_readdata;
    end
  end

  assign r0_rvalid = r_rvalid;
  assign r0_rdata  = r_rvalid ? rom_readdata : '0;
  assign r0_done   = (state == ST_LAST);
  assign r1_ack    = r_ack;
  assign r1_rdata  = r_ack ? (r_ack_rd ? rom_readdata : '0) : r_r1_rdata;
  assign rom_clken = 1'b1;

  // Memory port mux: renderer burst addresses or the latched bridge access.
  always_comb begin
    rom_chipselect = 1'b0;
    rom_address    = '0;
    rom_write      = 1'b0;
    rom_byteenable = '0;
    rom_writedata  = '0;
    case (state)
      ST_BURST: begin
        rom_chipselect = 1'b1;
        rom_address    = w_burst_addr;
        rom_byteenable = '1;
      end
      ST_SINGLE: begin
        rom_chipselect = 1'b1;
        rom_address    = r_r1_addr;
        rom_write      = r_r1_write & w_wr_allow;
        rom_byteenable = r_r1_write ? r_r1_be : '1;
        rom_writedata  = r_r1_write ? r_r1_wdata : '0;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_rom_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : tb_sprite_rom_arbiter
// Description : Self-checking bench: transaction-level schedule model of the
//               arbiter, directed scenarios with literal expectations and a
//               randomized two-requester phase; plus a WRITE_EN=0 instance.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_sprite_rom_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        r0_req, r0_rvalid, r0_done;
  logic [6:0]  r0_base;
  logic [4:0]  r0_len;
  logic [15:0] r0_rdata;
  logic        r1_req, r1_write, r1_ack;
  logic [6:0]  r1_addr;
  logic [15:0] r1_wdata, r1_rdata;
  logic [1:0]  r1_be;
  logic [6:0]  rom_address;
  logic        rom_chipselect, rom_write, rom_clken;
  logic [1:0]  rom_byteenable;
  logic [15:0] rom_writedata;
  logic [15:0] rom_readdata = 16'h0;

  // second instance, writes disabled
  logic        n_r0_req, n_r0_rvalid, n_r0_done;
  logic [6:0]  n_r0_base;
  logic [4:0]  n_r0_len;
  logic [15:0] n_r0_rdata;
  logic        n_r1_req, n_r1_write, n_r1_ack;
  logic [6:0]  n_r1_addr;
  logic [15:0] n_r1_wdata, n_r1_rdata;
  logic [1:0]  n_r1_be;
  logic [6:0]  n_rom_address;
  logic        n_rom_chipselect, n_rom_write, n_rom_clken;
  logic [1:0]  n_rom_byteenable;
  logic [15:0] n_rom_writedata;
  logic [15:0] n_rom_readdata = 16'h0;

  int checks = 0;
  int errors = 0;

  sprite_rom_arbiter #(.DEPTH(128), .DW(16), .STARVE_LIM(4), .WRITE_EN(1)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_base(r0_base), .r0_len(r0_len),
    .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_done(r0_done),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_write(r1_write), .r1_wdata(r1_wdata),
    .r1_be(r1_be), .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .rom_address(rom_address), .rom_chipselect(rom_chipselect), .rom_write(rom_write),
    .rom_byteenable(rom_byteenable), .rom_writedata(rom_writedata),
    .rom_clken(rom_clken), .rom_readdata(rom_readdata)
  );

  sprite_rom_arbiter #(.DEPTH(128), .DW(16), .STARVE_LIM(4), .WRITE_EN(0)) dut_nw (
    .clk(clk), .reset(reset),
    .r0_req(n_r0_req), .r0_base(n_r0_base), .r0_len(n_r0_len),
    .r0_rvalid(n_r0_rvalid), .r0_rdata(n_r0_rdata), .r0_done(n_r0_done),
    .r1_req(n_r1_req), .r1_addr(n_r1_addr), .r1_write(n_r1_write), .r1_wdata(n_r1_wdata),
    .r1_be(n_r1_be), .r1_ack(n_r1_ack), .r1_rdata(n_r1_rdata),
    .rom_address(n_rom_address), .rom_chipselect(n_rom_chipselect), .rom_write(n_rom_write),
    .rom_byteenable(n_rom_byteenable), .rom_writedata(n_rom_writedata),
    .rom_clken(n_rom_clken), .rom_readdata(n_rom_readdata)
  );

  // Sprite memories: 1-cycle read latency, byte-enabled writes.
  logic [15:0] mem  [128];
  logic [15:0] nmem [128];
  always @(posedge clk) begin
    if (rom_chipselect) begin
      if (rom_write) begin
        if (rom_byteenable[0]) mem[rom_address][7:0]  <= rom_writedata[7:0];
        if (rom_byteenable[1]) mem[rom_address][15:8] <= rom_writedata[15:8];
      end
      rom_readdata <= mem[rom_address];
    end
  end
  always @(posedge clk) begin
    if (n_rom_chipselect) begin
      if (n_rom_write) begin
        if (n_rom_byteenable[0]) nmem[n_rom_address][7:0]  <= n_rom_writedata[7:0];
        if (n_rom_byteenable[1]) nmem[n_rom_address][15:8] <= n_rom_writedata[15:8];
      end
      n_rom_readdata <= nmem[n_rom_address];
    end
  end

  logic nw_wrote = 1'b0;
  always @(negedge clk) if (n_rom_write === 1'b1) nw_wrote <= 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model: per-cycle expectation schedule ----------
  logic        e_cs [64];
  logic [6:0]  e_addr [64];
  logic        e_we [64];
  logic [1:0]  e_be [64];
  logic [15:0] e_wd [64];
  logic        e_rv [64];
  logic [15:0] e_rd [64];
  logic        e_done [64];
  logic        e_ack [64];
  logic [15:0] e_r1d [64];
  logic [15:0] mmem [128];

  int cyc = 0;
  int free_at = 0;
  int starve = 0;
  bit chk_en = 1'b0;

  int q_addr [$];
  int q_r0   [$];
  int q_ev   [$];

  task automatic clr(input int s);
    e_cs[s] = 1'b0; e_addr[s] = '0; e_we[s] = 1'b0; e_be[s] = '0; e_wd[s] = '0;
    e_rv[s] = 1'b0; e_rd[s] = '0; e_done[s] = 1'b0; e_ack[s] = 1'b0; e_r1d[s] = '0;
  endtask

  initial for (int i = 0; i < 64; i++) clr(i);

  always @(negedge clk) begin : p_cmp
    int   s, s1, s2;
    logic ack_now, r1w;
    logic [6:0] a;
    if (chk_en) begin
      s = cyc % 64;
      chk("chipselect", rom_chipselect, e_cs[s]);
      chk("rom_write", rom_write, e_cs[s] & e_we[s]);
      chk("clken", rom_clken, 1);
      if (e_cs[s]) begin
        chk("rom_address", rom_address, e_addr[s]);
        chk("byteenable", rom_byteenable, e_be[s]);
        if (e_we[s]) chk("writedata", rom_writedata, e_wd[s]);
      end
      chk("r0_rvalid", r0_rvalid, e_rv[s]);
      if (e_rv[s]) chk("r0_rdata", r0_rdata, e_rd[s]);
      chk("r0_done", r0_done, e_done[s]);
      chk("r1_ack", r1_ack, e_ack[s]);
      if (e_ack[s]) chk("r1_rdata", r1_rdata, e_r1d[s]);

      if (rom_chipselect) q_addr.push_back(int'(rom_address));
      if (r0_rvalid)      q_r0.push_back(int'(r0_rdata));
      if (r0_done)        q_ev.push_back(0);
      if (r1_ack)         q_ev.push_back(1);

      ack_now = e_ack[s];
      clr(s);

      if (reset) begin
        for (int i = 0; i < 64; i++) clr(i);
        starve  = 0;
        free_at = cyc + 1;
      end else if (cyc >= free_at) begin
        r1w = r1_req && !ack_now;
        if (r1w && (!r0_req || starve == 4)) begin
          s1 = (cyc + 1) % 64;
          e_cs[s1] = 1'b1; e_addr[s1] = r1_addr; e_we[s1] = r1_write;
          e_be[s1] = r1_write ? r1_be : 2'b11; e_wd[s1] = r1_wdata;
          s2 = (cyc + 2) % 64;
          e_ack[s2] = 1'b1;
          e_r1d[s2] = r1_write ? 16'h0 : mmem[r1_addr];
          if (r1_write) begin
            if (r1_be[0]) mmem[r1_addr][7:0]  = r1_wdata[7:0];
            if (r1_be[1]) mmem[r1_addr][15:8] = r1_wdata[15:8];
          end
          starve  = 0;
          free_at = cyc + 2;
        end else if (r0_req) begin
          if (r1w) starve++;
          for (int i = 0; i < int'(r0_len); i++) begin
            a  = 7'((int'(r0_base) + i) % 128);
            s1 = (cyc + 1 + i) % 64;
            e_cs[s1] = 1'b1; e_addr[s1] = a; e_be[s1] = 2'b11;
            s2 = (cyc + 2 + i) % 64;
            e_rv[s2] = 1'b1; e_rd[s2] = mmem[a];
          end
          e_done[(cyc + 1 + int'(r0_len)) % 64] = 1'b1;
          free_at = cyc + int'(r0_len) + 2;
        end
      end
    end
    cyc++;
  end

  // ---------------- directed helpers ----------------------------------------
  task automatic r0_burst(input logic [6:0] b, input logic [4:0] l, output int lat);
    bit got;
    r0_base = b; r0_len = l; r0_req = 1'b1;
    lat = 0; got = 0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (r0_done) got = 1; else lat++;
    end
    chk("r0_done_seen", got, 1);
    @(posedge clk); #1;
    r0_req = 1'b0;
  endtask

  task automatic r1_access(input logic [6:0] ad, input logic w, input logic [15:0] wd,
                           input logic [1:0] be, output int lat, output logic [15:0] d);
    bit got;
    r1_addr = ad; r1_write = w; r1_wdata = wd; r1_be = be; r1_req = 1'b1;
    lat = 0; got = 0; d = '0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (r1_ack) begin got = 1; d = r1_rdata; end else lat++;
    end
    chk("r1_ack_seen", got, 1);
    @(posedge clk); #1;
    r1_req = 1'b0;
  endtask

  task automatic nw_access(input logic [6:0] ad, input logic w, input logic [15:0] wd,
                           input logic [1:0] be, output int lat, output logic [15:0] d);
    bit got;
    n_r1_addr = ad; n_r1_write = w; n_r1_wdata = wd; n_r1_be = be; n_r1_req = 1'b1;
    lat = 0; got = 0; d = '0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (n_r1_ack) begin got = 1; d = n_r1_rdata; end else lat++;
    end
    chk("nw_ack_seen", got, 1);
    @(posedge clk); #1;
    n_r1_req = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  // ---------------- main sequence -------------------------------------------
  initial begin : p_main
    int          lat;
    logic [15:0] d;
    logic        sd, sa;
    bit          got;
    logic [6:0]  exp_wrap [4];

    for (int i = 0; i < 128; i++) begin
      mem[i]  = 16'h1000 + 16'(i);
      nmem[i] = 16'h1000 + 16'(i);
      mmem[i] = 16'h1000 + 16'(i);
    end
    reset = 1'b1;
    r0_req = 0; r0_base = 0; r0_len = 0;
    r1_req = 0; r1_addr = 0; r1_write = 0; r1_wdata = 0; r1_be = 0;
    n_r0_req = 0; n_r0_base = 0; n_r0_len = 0;
    n_r1_req = 0; n_r1_addr = 0; n_r1_write = 0; n_r1_wdata = 0; n_r1_be = 0;
    repeat (3) @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_cs", rom_chipselect, 0);
    chk("rst_write", rom_write, 0);
    chk("rst_addr", rom_address, 0);
    chk("rst_be", rom_byteenable, 0);
    chk("rst_rvalid", r0_rvalid, 0);
    chk("rst_done", r0_done, 0);
    chk("rst_ack", r1_ack, 0);
    chk("rst_r1_rdata", r1_rdata, 0);
    @(posedge clk); #1;

    // burst base 10 len 4
    q_addr.delete(); q_r0.delete();
    r0_burst(7'd10, 5'd4, lat);
    chk("b1_latency", lat, 5);
    chk("b1_naddr", q_addr.size(), 4);
    chk("b1_ndata", q_r0.size(), 4);
    for (int i = 0; i < 4 && i < q_addr.size() && i < q_r0.size(); i++) begin
      chk("b1_addr", q_addr[i], 10 + i);
      chk("b1_data", q_r0[i], 32'h100A + i);
    end

    // wrapping burst
    exp_wrap[0] = 7'd126; exp_wrap[1] = 7'd127; exp_wrap[2] = 7'd0; exp_wrap[3] = 7'd1;
    q_addr.delete(); q_r0.delete();
    r0_burst(7'd126, 5'd4, lat);
    chk("wrap_naddr", q_addr.size(), 4);
    chk("wrap_ndata", q_r0.size(), 4);
    for (int i = 0; i < 4 && i < q_addr.size() && i < q_r0.size(); i++) begin
      chk("wrap_addr", q_addr[i], exp_wrap[i]);
      chk("wrap_data", q_r0[i], 32'h1000 + exp_wrap[i]);
    end

    // single read, byte write, read-back
    r1_access(7'd5, 1'b0, 16'h0, 2'b00, lat, d);
    chk("rd5_latency", lat, 2);
    chk("rd5_data", d, 16'h1005);
    r1_access(7'd7, 1'b1, 16'hBEEF, 2'b01, lat, d);
    chk("wr7_latency", lat, 2);
    chk("wr7_rdata", d, 16'h0000);
    r1_access(7'd7, 1'b0, 16'h0, 2'b00, lat, d);
    chk("rd7_data", d, 16'h10EF);

    // zero-length burst
    q_addr.delete(); q_r0.delete();
    r0_burst(7'd20, 5'd0, lat);
    chk("zero_latency", lat, 1);
    chk("zero_naddr", q_addr.size(), 0);
    chk("zero_ndata", q_r0.size(), 0);

    // starvation: both held, 4 bursts then one bridge access then renderer
    q_ev.delete();
    r0_base = 7'd50; r0_len = 5'd1; r1_addr = 7'd3; r1_write = 1'b0;
    r0_req = 1'b1; r1_req = 1'b1;
    got = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      sd = r0_done; sa = r1_ack;
      @(posedge clk); #1;
      if (sa) r1_req = 1'b0;
      if (q_ev.size() >= 6 && sd) got = 1;
    end
    r0_req = 1'b0;
    chk("starve_seen", got, 1);
    for (int i = 0; i < 6 && i < q_ev.size(); i++) chk("starve_order", q_ev[i], (i == 4) ? 1 : 0);
    repeat (3) @(posedge clk); #1;

    // reset during the second address of a len-8 burst
    q_addr.delete(); q_ev.delete();
    r0_base = 7'd40; r0_len = 5'd8; r0_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; r0_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_cs", rom_chipselect, 0);
    chk("abort_rvalid", r0_rvalid, 0);
    chk("abort_done", r0_done, 0);
    chk("abort_ack", r1_ack, 0);
    repeat (20) @(negedge clk);
    chk("abort_no_done", q_ev.size(), 0);
    chk("abort_naddr", q_addr.size(), 2);
    @(posedge clk); #1;
    q_r0.delete();
    r0_burst(7'd40, 5'd3, lat);
    chk("after_rst_latency", lat, 4);
    chk("after_rst_ndata", q_r0.size(), 3);
    for (int i = 0; i < 3 && i < q_r0.size(); i++) chk("after_rst_data", q_r0[i], 32'h1028 + i);

    // randomized traffic from both requesters
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      sd = r0_done; sa = r1_ack;
      @(posedge clk); #1;
      if (r0_req && sd) r0_req = 1'b0;
      if (r1_req && sa) r1_req = 1'b0;
      if (!r0_req && $urandom_range(0, 3) == 0) begin
        r0_base = 7'($urandom);
        r0_len  = 5'($urandom_range(0, 16));
        r0_req  = 1'b1;
      end
      if (!r1_req && $urandom_range(0, 2) == 0) begin
        r1_addr  = 7'($urandom);
        r1_write = 1'($urandom_range(0, 1));
        r1_wdata = 16'($urandom);
        r1_be    = 2'($urandom_range(0, 3));
        r1_req   = 1'b1;
      end
    end
    for (int k = 0; k < 300 && (r0_req || r1_req); k++) begin
      @(negedge clk);
      sd = r0_done; sa = r1_ack;
      @(posedge clk); #1;
      if (r0_req && sd) r0_req = 1'b0;
      if (r1_req && sa) r1_req = 1'b0;
    end
    chk("drain", {r0_req, r1_req}, 0);

    // writes disabled: ack still pulses, memory unchanged
    nw_access(7'd9, 1'b1, 16'hBEEF, 2'b11, lat, d);
    chk("nw_wr_latency", lat, 2);
    nw_access(7'd9, 1'b0, 16'h0, 2'b00, lat, d);
    chk("nw_rd_latency", lat, 2);
    chk("nw_rd_data", d, 16'h1009);
    chk("nw_no_write", nw_wrote, 0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
